// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and constants for the AES round scheduler
package aes_pkg;

  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  localparam logic OPT_ENC = 1'b0;
  localparam logic OPT_DEC = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREADD,
    S_ROUND,
    S_FINAL,
    S_HOLD,
    S_ERROR
  } sched_state_t;

endpackage

// File: rtl/stall_counter.sv
// rtl/stall_counter.sv - consecutive-stall counter with terminal flag at TIMEOUT
module stall_counter #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (n_rst || clr) begin
      count_q <= '0;
    end else if (en && !tc) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign tc = (count_q == CW'(TIMEOUT));

endmodule

// File: rtl/aes_round_scheduler.sv
// rtl/aes_round_scheduler.sv - FSM sequencing pre-add, NR-1 rounds and final round per block
module aes_round_scheduler
  import aes_pkg::*;
#(
  parameter int NR      = NR_128,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       blk_valid,
  output logic       blk_ready,
  input  logic       opt_mode,
  input  logic       key_ready,
  output logic [3:0] rk_idx,
  input  logic       rk_valid,
  output logic       data_load,
  output logic       round_en,
  output logic       preadd,
  output logic       skip_mix,
  output logic       inv,
  output logic [3:0] round_num,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       err,
  input  logic       clr_err
);

  localparam logic [3:0] NR4 = 4'(NR);

  sched_state_t state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic         inv_q, inv_d;
  logic         err_q, err_d;
  logic         active;
  logic         stall_tc;

  assign active = (state_q == S_PREADD) || (state_q == S_ROUND) || (state_q == S_FINAL);

  // The counter only runs while a key fetch is outstanding in an active stage.
  stall_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_stall (
    .clk  (clk),
    .n_rst(n_rst),
    .clr  (!active || rk_valid),
    .en   (active && !rk_valid),
    .tc   (stall_tc)
  );

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q <= S_IDLE;
      round_q <= '0;
      inv_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      inv_q   <= inv_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    inv_d     = inv_q;
    err_d     = err_q;
    blk_ready = 1'b0;
    data_load = 1'b0;
    round_en  = 1'b0;
    preadd    = 1'b0;
    skip_mix  = 1'b0;
    out_valid = 1'b0;
    rk_idx    = '0;
    round_num = round_q;
    inv       = inv_q;
    err       = err_q;
    busy      = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        blk_ready = key_ready;
        if (blk_valid && key_ready) begin
          data_load = 1'b1;
          inv_d     = (opt_mode == OPT_DEC);
          round_d   = '0;
          state_d   = S_PREADD;
        end
      end
      S_PREADD: begin
        rk_idx = inv_q ? NR4 : 4'd0;
        if (stall_tc) begin
          err_d   = 1'b1;
          state_d = S_ERROR;
        end else if (rk_valid) begin
          preadd   = 1'b1;
          round_en = 1'b1;
          round_d  = 4'd1;
          state_d  = S_ROUND;
        end
      end
      S_ROUND: begin
        rk_idx = inv_q ? (NR4 - round_q) : round_q;
        if (stall_tc) begin
          err_d   = 1'b1;
          state_d = S_ERROR;
        end else if (rk_valid) begin
          round_en = 1'b1;
          round_d  = round_q + 4'd1;
          if (round_q == NR4 - 4'd1) state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        rk_idx   = inv_q ? 4'd0 : NR4;
        skip_mix = 1'b1;
        if (stall_tc) begin
          err_d   = 1'b1;
          state_d = S_ERROR;
        end else if (rk_valid) begin
          round_en = 1'b1;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        out_valid = 1'b1;
        round_num = NR4;
        if (out_ready) state_d = S_IDLE;
      end
      S_ERROR: begin
        if (clr_err) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs read as all-zero for the whole reset cycle.
    if (n_rst) begin
      blk_ready = 1'b0;
      data_load = 1'b0;
      round_en  = 1'b0;
      preadd    = 1'b0;
      skip_mix  = 1'b0;
      out_valid = 1'b0;
      rk_idx    = '0;
      round_num = '0;
      inv       = 1'b0;
      err       = 1'b0;
      busy      = 1'b0;
    end
  end

endmodule

// File: tb/tb_aes_round_scheduler.sv
// tb/tb_aes_round_scheduler.sv - directed-vector bench for aes_round_scheduler
module tb_aes_round_scheduler;

  localparam int NR = 10;

  logic       clk = 1'b0;
  logic       n_rst, blk_valid, opt_mode, key_ready, rk_valid, out_ready, clr_err;
  logic       blk_ready, data_load, round_en, preadd, skip_mix, inv, out_valid, busy, err;
  logic [3:0] rk_idx, round_num;
  logic [16:0] all_out;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  aes_round_scheduler #(.NR(NR), .TIMEOUT(15)) dut (
    .clk(clk), .n_rst(n_rst), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .opt_mode(opt_mode), .key_ready(key_ready), .rk_idx(rk_idx), .rk_valid(rk_valid),
    .data_load(data_load), .round_en(round_en), .preadd(preadd), .skip_mix(skip_mix),
    .inv(inv), .round_num(round_num), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .err(err), .clr_err(clr_err)
  );

  assign all_out = {blk_ready, data_load, round_en, preadd, skip_mix, inv, round_num,
                    out_valid, busy, err, rk_idx};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    #1;
    vectors++;
    if (all_out !== 17'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    n_rst = 1'b0;
    #1;
    vectors++;
    if ({blk_ready, busy, err, inv, round_num} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0}) begin
      miscompares++;
      $display("FAIL reset_idle: got rdy=%b busy=%b err=%b inv=%b rn=%0d want 1 0 0 0 0",
               blk_ready, busy, err, inv, round_num);
    end
  endtask

  // One unstalled block; decrypt also toggles opt_mode and drops key_ready mid-block.
  task automatic test_block(input bit dec);
    logic [12:0] exp_v, obs_v;
    logic [3:0]  exp_idx, exp_rn;
    tick();
    blk_valid = 1'b1;
    opt_mode  = dec;
    rk_valid  = 1'b1;
    #1;
    vectors++;
    if ({data_load, blk_ready} !== 2'b11) begin
      miscompares++;
      $display("FAIL accept_dec%0d: got load=%b rdy=%b want 1 1", dec, data_load, blk_ready);
    end
    for (int c = 1; c <= NR + 1; c++) begin
      tick();
      blk_valid = 1'b0;
      if (dec && c == 5) opt_mode = 1'b0;
      if (dec && c == 6) key_ready = 1'b0;
      #1;
      exp_idx = dec ? 4'(NR - (c - 1)) : 4'(c - 1);
      exp_rn  = (c == NR + 1) ? 4'(NR) : 4'(c - 1);
      exp_v = {exp_idx, exp_rn, (c == 1), (c == NR + 1), 1'b1, 1'b0, dec};
      obs_v = {rk_idx, round_num, preadd, skip_mix, round_en, out_valid, inv};
      vectors++;
      if (obs_v !== exp_v) begin
        miscompares++;
        $display("FAIL block_dec%0d_c%0d: got idx/rn/pre/skip/en/ov/inv=%h want %h",
                 dec, c, obs_v, exp_v);
      end
    end
    key_ready = 1'b1;
    tick();
    #1;
    vectors++;
    if ({out_valid, blk_ready, round_num, inv} !== {1'b1, 1'b0, 4'(NR), dec}) begin
      miscompares++;
      $display("FAIL hold_dec%0d: got ov=%b rdy=%b rn=%0d inv=%b want 1 0 %0d %0d",
               dec, out_valid, blk_ready, round_num, inv, NR, dec);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    vectors++;
    if ({busy, out_valid, blk_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL release_dec%0d: got busy=%b ov=%b rdy=%b want 0 0 1",
               dec, busy, out_valid, blk_ready);
    end
  endtask

  task automatic test_stall();
    bit seen;
    seen = 1'b0;
    tick();
    blk_valid = 1'b1;
    opt_mode  = 1'b0;
    #1;
    for (int c = 1; c <= 40 && !seen; c++) begin
      tick();
      blk_valid = 1'b0;
      rk_valid  = !(c >= 5 && c <= 7);
      #1;
      if (c >= 5 && c <= 8) begin
        vectors++;
        if ({round_num, round_en} !== {4'd4, (c == 8)}) begin
          miscompares++;
          $display("FAIL stall_c%0d: got rn=%0d en=%b want 4 %0d", c, round_num, round_en, (c == 8));
        end
      end
      if (out_valid) begin
        seen = 1'b1;
        vectors++;
        if (c != NR + 5) begin
          miscompares++;
          $display("FAIL stall_latency: got %0d want %0d", c, NR + 5);
        end
      end
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL stall_latency: got no out_valid want %0d", NR + 5);
    end
    rk_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_timeout();
    tick();
    blk_valid = 1'b1;
    #1;
    for (int c = 1; c <= 19; c++) begin
      tick();
      blk_valid = (c == 19);
      rk_valid  = (c < 3);
      #1;
      if (c == 18) begin
        vectors++;
        if ({err, busy} !== 2'b01) begin
          miscompares++;
          $display("FAIL timeout_early: got err=%b busy=%b want 0 1", err, busy);
        end
      end
      if (c == 19) begin
        vectors++;
        if ({err, blk_ready, data_load, round_en, preadd, skip_mix, out_valid} !== 7'b1000000) begin
          miscompares++;
          $display("FAIL timeout_err: got err/rdy/load/en/pre/skip/ov=%b want 1000000",
                   {err, blk_ready, data_load, round_en, preadd, skip_mix, out_valid});
        end
      end
    end
    blk_valid = 1'b0;
    rk_valid  = 1'b1;
    clr_err   = 1'b1;
    tick();
    clr_err = 1'b0;
    #1;
    vectors++;
    if ({err, busy, blk_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL clr_err: got err=%b busy=%b rdy=%b want 0 0 1", err, busy, blk_ready);
    end
  endtask

  // Holds the result, then accepts a new block right after release and resets it mid-round.
  task automatic test_back_to_back();
    tick();
    blk_valid = 1'b1;
    #1;
    for (int c = 1; c <= NR + 1; c++) begin
      tick();
      blk_valid = 1'b0;
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      blk_valid = 1'b1;
      #1;
      vectors++;
      if ({out_valid, blk_ready, data_load} !== 3'b100) begin
        miscompares++;
        $display("FAIL hold_wait_%0d: got ov=%b rdy=%b load=%b want 1 0 0",
                 c, out_valid, blk_ready, data_load);
      end
    end
    tick();
    out_ready = 1'b1;
    #1;
    vectors++;
    if ({out_valid, blk_ready, data_load} !== 3'b100) begin
      miscompares++;
      $display("FAIL hold_release: got ov=%b rdy=%b load=%b want 1 0 0", out_valid, blk_ready, data_load);
    end
    tick();
    out_ready = 1'b0;
    #1;
    vectors++;
    if ({blk_ready, data_load} !== 2'b11) begin
      miscompares++;
      $display("FAIL next_accept: got rdy=%b load=%b want 1 1", blk_ready, data_load);
    end
    for (int c = 1; c <= 7; c++) begin
      tick();
      blk_valid = 1'b0;
    end
    vectors++;
    if (round_num !== 4'd6) begin
      miscompares++;
      $display("FAIL pre_reset_round: got %0d want 6", round_num);
    end
    n_rst = 1'b1;
    #1;
    vectors++;
    if (all_out !== 17'h0) begin
      miscompares++;
      $display("FAIL mid_reset: got %h want 0", all_out);
    end
    tick();
    n_rst     = 1'b0;
    key_ready = 1'b0;
    blk_valid = 1'b1;
    #1;
    vectors++;
    if (all_out !== 17'h0) begin
      miscompares++;
      $display("FAIL post_reset_idle: got %h want 0", all_out);
    end
    tick();
    #1;
    vectors++;
    if ({busy, data_load, blk_ready} !== 3'b000) begin
      miscompares++;
      $display("FAIL no_key_accept: got busy=%b load=%b rdy=%b want 0 0 0", busy, data_load, blk_ready);
    end
    begin
      bit any_ov;
      any_ov = 1'b0;
      for (int c = 0; c < 15; c++) begin
        tick();
        any_ov = any_ov | out_valid;
      end
      vectors++;
      if (any_ov !== 1'b0) begin
        miscompares++;
        $display("FAIL abandoned_out_valid: got %b want 0", any_ov);
      end
    end
    blk_valid = 1'b0;
    key_ready = 1'b1;
  endtask

  initial begin
    n_rst     = 1'b1;
    blk_valid = 1'b0;
    opt_mode  = 1'b0;
    key_ready = 1'b1;
    rk_valid  = 1'b1;
    out_ready = 1'b0;
    clr_err   = 1'b0;
    test_reset();
    test_block(1'b0);
    test_block(1'b1);
    test_stall();
    test_timeout();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
